// File: rtl/rf_wb_scheduler_if.sv
// Bundle of issue, writeback and register-file write signals around the scheduler.
// The master side drives requests; the slave side is the scheduler itself.
interface rf_wb_scheduler_if #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32
);
    logic                iss_valid;
    logic [4:0]          iss_rs1;
    logic [4:0]          iss_rs2;
    logic                iss_use_rs1;
    logic                iss_use_rs2;
    logic                iss_wen;
    logic [4:0]          iss_rd;
    logic                iss_ready;

    logic                wb0_valid;
    logic [4:0]          wb0_rd;
    logic [XLEN-1:0]     wb0_data;
    logic                wb0_ready;

    logic                wb1_valid;
    logic [4:0]          wb1_rd;
    logic [XLEN-1:0]     wb1_data;
    logic                wb1_ready;

    logic                rf_we;
    logic [4:0]          rf_rd;
    logic [XLEN-1:0]     rf_din;
    logic [NUM_REGS-1:0] busy_vec;
    logic                sb_err;

    modport master (
        output iss_valid, iss_rs1, iss_rs2, iss_use_rs1, iss_use_rs2, iss_wen, iss_rd,
        input  iss_ready,
        output wb0_valid, wb0_rd, wb0_data,
        input  wb0_ready,
        output wb1_valid, wb1_rd, wb1_data,
        input  wb1_ready,
        input  rf_we, rf_rd, rf_din, busy_vec, sb_err
    );

    modport slave (
        input  iss_valid, iss_rs1, iss_rs2, iss_use_rs1, iss_use_rs2, iss_wen, iss_rd,
        output iss_ready,
        input  wb0_valid, wb0_rd, wb0_data,
        output wb0_ready,
        input  wb1_valid, wb1_rd, wb1_data,
        output wb1_ready,
        output rf_we, rf_rd, rf_din, busy_vec, sb_err
    );
endinterface

// File: rtl/rf_wb_scheduler.sv
// Issue scoreboard (per-register pending-write counters, RAW/overflow stall) and
// round-robin arbiter sharing the single register-file write port between two sources.
module rf_wb_scheduler #(
    parameter int NUM_REGS    = 32,
    parameter int XLEN        = 32,
    parameter int MAX_PENDING = 3
) (
    input logic              clk,
    input logic              reset,
    rf_wb_scheduler_if.slave bus_io
);
    localparam int CW = $clog2(MAX_PENDING + 1);
    localparam logic [CW-1:0] CntMax = CW'(MAX_PENDING);

    logic [CW-1:0]       pendCnt_q [NUM_REGS];
    logic [CW-1:0]       pendCnt_d [NUM_REGS];
    logic                prio_q;
    logic                prio_d;
    logic                sbErr_q;
    logic                sbErr_d;

    logic                stall;
    logic                issAccept;
    logic                grant0;
    logic                grant1;
    logic                grantAny;
    logic [4:0]          grantRd;
    logic [XLEN-1:0]     grantData;
    logic [NUM_REGS-1:0] incHit;
    logic [NUM_REGS-1:0] decHit;
    logic [NUM_REGS-1:0] busyVec;

    // Stall looks only at current counts, so a same-cycle retirement never unblocks issue.
    always_comb begin
        stall = 1'b0;
        if (bus_io.iss_use_rs1 && bus_io.iss_rs1 != 5'd0 && pendCnt_q[bus_io.iss_rs1] != '0)
            stall = 1'b1;
        if (bus_io.iss_use_rs2 && bus_io.iss_rs2 != 5'd0 && pendCnt_q[bus_io.iss_rs2] != '0)
            stall = 1'b1;
        if (bus_io.iss_wen && bus_io.iss_rd != 5'd0 && pendCnt_q[bus_io.iss_rd] == CntMax)
            stall = 1'b1;
    end

    assign bus_io.iss_ready = !reset && !stall;
    assign issAccept        = bus_io.iss_valid && bus_io.iss_ready;

    // Contested cycles serve the favoured source and hand priority to the loser.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        prio_d = prio_q;
        if (!reset) begin
            if (bus_io.wb0_valid && bus_io.wb1_valid) begin
                grant0 = !prio_q;
                grant1 = prio_q;
                prio_d = !prio_q;
            end else begin
                grant0 = bus_io.wb0_valid;
                grant1 = bus_io.wb1_valid;
            end
        end
        grantAny  = grant0 || grant1;
        grantRd   = grant0 ? bus_io.wb0_rd   : (grant1 ? bus_io.wb1_rd   : 5'd0);
        grantData = grant0 ? bus_io.wb0_data : (grant1 ? bus_io.wb1_data : '0);
    end

    assign bus_io.wb0_ready = grant0;
    assign bus_io.wb1_ready = grant1;
    assign bus_io.rf_we     = grantAny && grantRd != 5'd0;
    assign bus_io.rf_rd     = grantRd;
    assign bus_io.rf_din    = grantData;
    assign bus_io.sb_err    = sbErr_q;

    always_comb begin
        incHit  = '0;
        decHit  = '0;
        busyVec = '0;
        sbErr_d = sbErr_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            pendCnt_d[i] = pendCnt_q[i];
            busyVec[i]   = !reset && pendCnt_q[i] != '0;
            if (i != 0) begin
                incHit[i] = issAccept && bus_io.iss_wen && bus_io.iss_rd == 5'(i);
                decHit[i] = grantAny && grantRd == 5'(i) && pendCnt_q[i] != '0;
                if (incHit[i] && !decHit[i])
                    pendCnt_d[i] = pendCnt_q[i] + CW'(1);
                else if (decHit[i] && !incHit[i])
                    pendCnt_d[i] = pendCnt_q[i] - CW'(1);
            end
        end
        // A retirement with nothing outstanding is a pipeline bug; count saturates at zero.
        if (grantAny && grantRd != 5'd0 && pendCnt_q[grantRd] == '0)
            sbErr_d = 1'b1;
    end

    assign bus_io.busy_vec = busyVec;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                pendCnt_q[i] <= '0;
            end
            prio_q  <= 1'b0;
            sbErr_q <= 1'b0;
        end else begin
            pendCnt_q <= pendCnt_d;
            prio_q    <= prio_d;
            sbErr_q   <= sbErr_d;
        end
    end
endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Bench for rf_wb_scheduler: directed scenarios with literal expectations, then random
// traffic, all continuously compared against a per-register pending-count model.
module tb_rf_wb_scheduler;
    localparam int XLEN        = 32;
    localparam int NUM_REGS    = 32;
    localparam int MAX_PENDING = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;

    rf_wb_scheduler_if #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) bus ();

    rf_wb_scheduler #(
        .NUM_REGS   (NUM_REGS),
        .XLEN       (XLEN),
        .MAX_PENDING(MAX_PENDING)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus_io(bus)
    );

    always #5 clk = ~clk;

    int nTests = 0;
    int nFail  = 0;

    // Reference state: outstanding write count per register, priority owner, error flag.
    int   mPcnt [NUM_REGS];
    bit   mPrio = 1'b0;
    bit   mSbErr = 1'b0;
    bit   modelLive = 1'b0;

    bit          expReady;
    bit          mStall;
    int          winner;
    logic [4:0]  expRd;
    logic [31:0] expDin;
    bit          expWe;
    logic [31:0] expBusy;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nTests++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Every cycle: derive expected outputs from the model, compare, then advance the model.
    always @(negedge clk) begin
        if (modelLive) begin
            winner  = -1;
            expBusy = '0;
            if (reset) begin
                expReady = 1'b0;
            end else begin
                mStall = (bus.iss_use_rs1 && bus.iss_rs1 != 0 && mPcnt[bus.iss_rs1] > 0)
                      || (bus.iss_use_rs2 && bus.iss_rs2 != 0 && mPcnt[bus.iss_rs2] > 0)
                      || (bus.iss_wen && bus.iss_rd != 0 && mPcnt[bus.iss_rd] >= MAX_PENDING);
                expReady = !mStall;
                if (bus.wb0_valid && bus.wb1_valid) winner = mPrio ? 1 : 0;
                else if (bus.wb0_valid)             winner = 0;
                else if (bus.wb1_valid)             winner = 1;
                for (int i = 0; i < NUM_REGS; i++) expBusy[i] = (mPcnt[i] > 0);
            end
            expRd  = (winner == 0) ? bus.wb0_rd   : (winner == 1) ? bus.wb1_rd   : 5'd0;
            expDin = (winner == 0) ? bus.wb0_data : (winner == 1) ? bus.wb1_data : 32'd0;
            expWe  = (winner >= 0) && (expRd != 0);

            checkOutput("m_iss_ready", bus.iss_ready, expReady);
            checkOutput("m_wb0_ready", bus.wb0_ready, winner == 0);
            checkOutput("m_wb1_ready", bus.wb1_ready, winner == 1);
            checkOutput("m_rf_we",     bus.rf_we,     expWe);
            checkOutput("m_rf_rd",     bus.rf_rd,     expRd);
            checkOutput("m_rf_din",    bus.rf_din,    expDin);
            checkOutput("m_busy_vec",  bus.busy_vec,  expBusy);
            checkOutput("m_sb_err",    bus.sb_err,    mSbErr);

            if (reset) begin
                for (int i = 0; i < NUM_REGS; i++) mPcnt[i] = 0;
                mPrio  = 1'b0;
                mSbErr = 1'b0;
            end else begin
                if (expWe) begin
                    if (mPcnt[expRd] == 0) mSbErr = 1'b1;
                    else                   mPcnt[expRd] = mPcnt[expRd] - 1;
                end
                if (bus.iss_valid && expReady && bus.iss_wen && bus.iss_rd != 0)
                    mPcnt[bus.iss_rd] = mPcnt[bus.iss_rd] + 1;
                if (bus.wb0_valid && bus.wb1_valid) mPrio = (winner == 0);
            end
        end
    end

    task automatic applyStimulus(
        input logic iv, input logic u1, input logic [4:0] rs1, input logic u2, input logic [4:0] rs2,
        input logic wen, input logic [4:0] rd,
        input logic v0, input logic [4:0] rd0, input logic [31:0] d0,
        input logic v1, input logic [4:0] rd1, input logic [31:0] d1);
        bus.iss_valid   = iv;
        bus.iss_use_rs1 = u1;
        bus.iss_rs1     = rs1;
        bus.iss_use_rs2 = u2;
        bus.iss_rs2     = rs2;
        bus.iss_wen     = wen;
        bus.iss_rd      = rd;
        bus.wb0_valid   = v0;
        bus.wb0_rd      = rd0;
        bus.wb0_data    = d0;
        bus.wb1_valid   = v1;
        bus.wb1_rd      = rd1;
        bus.wb1_data    = d1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    int   pool[$];
    bit   accIss, got0, got1;
    logic [4:0] accRd;
    int   pick;

    initial begin
        idle();
        nextCycle();
        modelLive = 1'b1;

        // Reset gates every handshake even with a writeback pending.
        applyStimulus(1, 0, 0, 0, 0, 1, 4, 1, 4, 32'h1234, 0, 0, 0);
        @(negedge clk);
        checkOutput("rst_iss_ready", bus.iss_ready, 0);
        checkOutput("rst_wb0_ready", bus.wb0_ready, 0);
        checkOutput("rst_rf_we",     bus.rf_we,     0);
        checkOutput("rst_busy_vec",  bus.busy_vec,  0);
        nextCycle();
        reset = 1'b0;
        idle();
        @(negedge clk);
        checkOutput("rst_sb_err", bus.sb_err, 0);

        // Issue to x5, then a RAW reader of x5 stalls.
        nextCycle();
        applyStimulus(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("t1_issue_ready", bus.iss_ready, 1);
        nextCycle();
        applyStimulus(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("t1_busy5", bus.busy_vec[5], 1);
        checkOutput("t1_raw_stall", bus.iss_ready, 0);

        // Writeback of x5; no bypass in the retiring cycle.
        nextCycle();
        applyStimulus(1, 1, 5, 0, 0, 0, 0, 1, 5, 32'hDEAD, 0, 0, 0);
        @(negedge clk);
        checkOutput("t2_wb0_ready", bus.wb0_ready, 1);
        checkOutput("t2_rf_we",     bus.rf_we,     1);
        checkOutput("t2_rf_rd",     bus.rf_rd,     5);
        checkOutput("t2_rf_din",    bus.rf_din,    32'hDEAD);
        checkOutput("t2_no_bypass", bus.iss_ready, 0);
        nextCycle();
        applyStimulus(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("t2_busy5_clear", bus.busy_vec[5], 0);
        checkOutput("t2_raw_accept",  bus.iss_ready,   1);

        // Contested arbitration: wb0, wb1, wb0, then the held wb1 alone.
        for (int r = 11; r <= 13; r++) begin
            nextCycle();
            applyStimulus(1, 0, 0, 0, 0, 1, 5'(r), 0, 0, 0, 0, 0, 0);
        end
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 11, 32'hA, 1, 12, 32'hB);
        @(negedge clk);
        checkOutput("t3a_wb0_ready", bus.wb0_ready, 1);
        checkOutput("t3a_wb1_ready", bus.wb1_ready, 0);
        checkOutput("t3a_rf_rd",     bus.rf_rd,     11);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 13, 32'hC, 1, 12, 32'hB);
        @(negedge clk);
        checkOutput("t3b_wb0_ready", bus.wb0_ready, 0);
        checkOutput("t3b_wb1_ready", bus.wb1_ready, 1);
        checkOutput("t3b_rf_din",    bus.rf_din,    32'hB);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 13, 32'hC, 1, 0, 32'hD);
        @(negedge clk);
        checkOutput("t3c_wb0_ready", bus.wb0_ready, 1);
        checkOutput("t3c_rf_rd",     bus.rf_rd,     13);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hD);
        @(negedge clk);
        checkOutput("t3d_wb1_ready", bus.wb1_ready, 1);
        checkOutput("t3d_rf_we",     bus.rf_we,     0);
        nextCycle();
        idle();
        @(negedge clk);
        checkOutput("t3_busy_clear", bus.busy_vec, 0);

        // Saturate x7 at three outstanding writes.
        for (int k = 0; k < 3; k++) begin
            nextCycle();
            applyStimulus(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            checkOutput("t4_issue_x7", bus.iss_ready, 1);
        end
        nextCycle();
        applyStimulus(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_model_pcnt7", mPcnt[7], 3);
        @(negedge clk);
        checkOutput("t4_max_stall", bus.iss_ready, 0);
        nextCycle();
        applyStimulus(1, 0, 0, 0, 0, 1, 7, 1, 7, 32'h77, 0, 0, 0);
        @(negedge clk);
        checkOutput("t4_stall_same_cycle", bus.iss_ready, 0);
        checkOutput("t4_wb0_ready",        bus.wb0_ready, 1);
        nextCycle();
        applyStimulus(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("t4_issue_after_wb", bus.iss_ready, 1);

        // x0 is never tracked; a stray retirement of x9 latches the error.
        nextCycle();
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 1, 0, 32'h5555, 0, 0, 0);
        @(negedge clk);
        checkOutput("t5_iss_ready_x0", bus.iss_ready, 1);
        checkOutput("t5_wb0_ready_x0", bus.wb0_ready, 1);
        checkOutput("t5_rf_we_x0",     bus.rf_we,     0);
        checkOutput("t5_busy_x0",      bus.busy_vec,  32'h80);
        nextCycle();
        idle();
        @(negedge clk);
        checkOutput("t5_busy_after_x0", bus.busy_vec, 32'h80);
        checkOutput("t5_sb_err_clean",  bus.sb_err,   0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 32'h99);
        @(negedge clk);
        checkOutput("t5_wb1_ready_x9", bus.wb1_ready, 1);
        nextCycle();
        idle();
        checkOutput("t5_model_err", mSbErr, 1);
        @(negedge clk);
        checkOutput("t5_sb_err_set", bus.sb_err, 1);
        nextCycle();
        @(negedge clk);
        checkOutput("t5_sb_err_sticky", bus.sb_err, 1);

        // Reset mid-flight drops x3 and the pending wb1 request.
        nextCycle();
        applyStimulus(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0);
        nextCycle();
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 32'h33);
        @(negedge clk);
        checkOutput("t6_wb1_ready_rst", bus.wb1_ready, 0);
        checkOutput("t6_rf_we_rst",     bus.rf_we,     0);
        checkOutput("t6_busy_rst",      bus.busy_vec,  0);
        nextCycle();
        reset = 1'b0;
        idle();
        @(negedge clk);
        checkOutput("t6_busy_after", bus.busy_vec, 0);
        checkOutput("t6_sb_err_after", bus.sb_err, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h1, 1, 0, 32'h2);
        @(negedge clk);
        checkOutput("t6_prio_wb0", bus.wb0_ready, 1);
        checkOutput("t6_prio_wb1", bus.wb1_ready, 0);

        // Random traffic; writebacks only retire registers that were actually issued.
        nextCycle();
        idle();
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        accIss = 0;
        got0 = 0;
        got1 = 0;
        for (int c = 0; c < 3000; c++) begin
            nextCycle();
            if (accIss) pool.push_back(int'(accRd));
            bus.iss_valid   = ($urandom_range(0, 9) < 6);
            bus.iss_use_rs1 = $urandom_range(0, 1);
            bus.iss_rs1     = 5'($urandom_range(0, 7));
            bus.iss_use_rs2 = $urandom_range(0, 1);
            bus.iss_rs2     = 5'($urandom_range(0, 7));
            bus.iss_wen     = ($urandom_range(0, 9) < 7);
            bus.iss_rd      = 5'($urandom_range(0, 7));
            if (got0 || !bus.wb0_valid) begin
                bus.wb0_valid = 1'b0;
                if ($urandom_range(0, 15) == 0) begin
                    bus.wb0_valid = 1'b1;
                    bus.wb0_rd    = 5'd0;
                end else if (pool.size() > 0 && $urandom_range(0, 1) == 1) begin
                    pick = $urandom_range(0, pool.size() - 1);
                    bus.wb0_valid = 1'b1;
                    bus.wb0_rd    = 5'(pool[pick]);
                    pool.delete(pick);
                end
                bus.wb0_data = $urandom;
            end
            if (got1 || !bus.wb1_valid) begin
                bus.wb1_valid = 1'b0;
                if ($urandom_range(0, 15) == 0) begin
                    bus.wb1_valid = 1'b1;
                    bus.wb1_rd    = 5'd0;
                end else if (pool.size() > 0 && $urandom_range(0, 1) == 1) begin
                    pick = $urandom_range(0, pool.size() - 1);
                    bus.wb1_valid = 1'b1;
                    bus.wb1_rd    = 5'(pool[pick]);
                    pool.delete(pick);
                end
                bus.wb1_data = $urandom;
            end
            @(negedge clk);
            accIss = bus.iss_valid && bus.iss_ready && bus.iss_wen && bus.iss_rd != 0;
            accRd  = bus.iss_rd;
            got0   = bus.wb0_valid && bus.wb0_ready;
            got1   = bus.wb1_valid && bus.wb1_ready;
        end
        nextCycle();
        idle();
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
